l1_cache_merge_buffer: RTL and testbench
========================================

// Module: l1_cache_merge_buffer
// PURPOSE
//  Staging buffer between the L1 datapath and the cache data array.
//  Collects CPU stores (byte-masked words) into one cache line and merges them over a base line.
//  The base line comes from the data array on a hit or from the L2 fill on a miss.
//  Emits the merged line plus a dirty-byte mask through a valid/ready handshake.
//  Replaces the single-shot combinational write merge. Adds multi-store accumulation and
//  store-before-fill ordering.
// PARAMETERS
//  WORD_W   16                 data word width in bits, multiple of 8
//  WORDS    16                 words per cache line
//  BE_W     WORD_W/8           byte enables per word (derived)
//  OFF_W    $clog2(WORDS)      word offset width (derived)
//  LINE_W   WORD_W*WORDS       line width in bits (derived)
// PORTS
//  clk          in   1        clock, rising edge
//  reset_n      in   1        asynchronous active-low reset
//  st_valid     in   1        store beat valid
//  st_ready     out  1        store beat accepted when st_valid&st_ready
//  st_offset    in   OFF_W    word index within line
//  st_wdata     in   WORD_W   store data
//  st_wmask     in   BE_W     byte enables; bit b covers bits [8b+7:8b]
//  base_valid   in   1        base line present this cycle (array read or L2 fill)
//  base_line    in   LINE_W   base line data
//  commit       in   1        no further stores for this line; close when base held
//  abort        in   1        discard buffer contents
//  out_valid    out  1        merged line available
//  out_ready    in   1        consumer takes line when out_valid&out_ready
//  out_line     out  LINE_W   merged line
//  out_dirty    out  LINE_W/8 per-byte written mask (1 = came from a store)
//  dup_base     out  1        one-cycle pulse: base_valid while base already held (ignored)
// BEHAVIOUR
//  Reset: state IDLE; line and dirty registers 0; have_base 0; out_valid 0; st_ready 1; dup_base 0.
//  States:
//   IDLE   - empty. A store beat or base_valid moves to ACCUM.
//   ACCUM  - stores and base captured; st_ready=1.
//            commit with (have_base | base_valid) moves to DRAIN next cycle.
//   DRAIN  - out_valid=1, st_ready=0, inputs ignored. out_ready moves to IDLE;
//            line, dirty and have_base clear on that edge.
//  Store accept: selected bytes are written to the line register and set in dirty.
//   Bytes written later by another store overwrite earlier ones.
//  Base capture: only bytes with dirty=0 are loaded, so stores always win, whatever the order.
//   Base and store in the same cycle: the store bytes win; other bytes take base.
//  commit without a base held stays in ACCUM (commit is level-sampled) until base arrives.
//  Store and commit in the same cycle: the store is included in the line.
//  base_valid while have_base=1 in ACCUM: the base is ignored and dup_base pulses.
//  abort in IDLE/ACCUM: goes to IDLE and clears everything. abort beats a same-cycle commit.
//   abort in DRAIN is ignored.
//  Latency: commit edge to out_valid = 1 cycle. out_line and out_dirty are stable while out_valid=1.
//  Zero stores then commit: out_line = base, out_dirty = 0.
// CONFIGURATION
//  L1_MERGE_STATS_EN defined: adds ports stat_lines[15:0] and stat_bytes[15:0].
//   Both are saturating counters, reset 0.
//   stat_lines counts out handshakes; stat_bytes counts accepted enabled store bytes.
//  L1_MERGE_STATS_EN undefined: the ports and counters are absent; behaviour is otherwise identical.
// STRUCTURE
//  The shared package lc3b_types holds the merge_state_t enum (IDLE/ACCUM/DRAIN) and WORD_W/WORDS defaults.
//  One sub-module, l1_merge_byte_lane: the per-byte register with store/base priority
//   and dirty bit, generated LINE_W/8 times.
//  FSM, handshake and stats counters stay in the top module.
// TESTING
//  1 Base 0x1111.. then store off=3 data=0xABCD mask=11, commit:
//    word3=ABCD, rest 1111, dirty bytes 6,7 only.
//  2 Store off=0 mask=01 data=0x00EE, then L2 base 0x2222..:
//    word0=0x22EE, base did not overwrite the store byte.
//  3 Commit with no base for 5 cycles: out_valid stays 0; base arrives -> out_valid the next cycle.
//  4 Stores off=2 data 0x1234 then 0x5678 (mask 11), base, commit:
//    word2=0x5678; same-cycle store+commit is included.
//  5 DRAIN with out_ready low for 3 cycles: st_ready=0, out_line stable;
//    out_ready -> IDLE, next line starts clean.
//  6 Second base during ACCUM -> dup_base pulse, data unchanged;
//    abort with commit -> IDLE, no out_valid; reset_n low in DRAIN -> out_valid 0 immediately.

Source files
------------

// File: rtl/lc3b_types.sv
// ============================================================================
//  Module      : lc3b_types (package)
//  Description : Shared types and default geometry for the L1 merge buffer.
//                Holds the merge_state_t FSM encoding and WORD_W/WORDS
//                defaults used by l1_cache_merge_buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lc3b_types;

    localparam int WORD_W_DEF = 16;
    localparam int WORDS_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } merge_state_t;

endpackage

`default_nettype wire

// File: rtl/l1_merge_byte_lane.sv
// ============================================================================
//  Module      : l1_merge_byte_lane
//  Description : One byte of the merge line. Holds the data byte and its
//                dirty bit. A store always wins; a base byte is only loaded
//                while the byte is still clean, so a late fill never
//                overwrites store data.
//  Ports       : clk, reset_n   - clock, async active-low reset
//                clr_i          - synchronous clear of data and dirty
//                st_we_i/st_byte_i     - store write of this byte
//                base_we_i/base_byte_i - base capture for this byte
//                byte_o, dirty_o       - current byte and dirty flag
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l1_merge_byte_lane (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr_i,
    input  logic       st_we_i,
    input  logic [7:0] st_byte_i,
    input  logic       base_we_i,
    input  logic [7:0] base_byte_i,
    output logic [7:0] byte_o,
    output logic       dirty_o
);

    logic [7:0] data_q;
    logic       dirty_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= 8'h00;
            dirty_q <= 1'b0;
        end else if (clr_i) begin
            data_q  <= 8'h00;
            dirty_q <= 1'b0;
        end else if (st_we_i) begin
            data_q  <= st_byte_i;
            dirty_q <= 1'b1;
        end else if (base_we_i && !dirty_q) begin
            data_q  <= base_byte_i;
        end
    end

    assign byte_o  = data_q;
    assign dirty_o = dirty_q;

endmodule

`default_nettype wire

// File: rtl/l1_cache_merge_buffer.sv
// ============================================================================
//  Module      : l1_cache_merge_buffer
//  Description : Staging buffer between the L1 datapath and the data array.
//                Accumulates byte-masked stores into one line, merges them
//                over a base line (array hit or L2 fill, in either order) and
//                emits the merged line plus a dirty-byte mask via
//                out_valid/out_ready.
//  Ports       : clk, reset_n                  - clock, async active-low reset
//                st_valid/st_ready/st_offset/st_wdata/st_wmask - store beats
//                base_valid/base_line          - base line capture
//                commit, abort                 - close / discard the line
//                out_valid/out_ready/out_line/out_dirty - merged line output
//                dup_base                      - pulse on an ignored second base
//                stat_lines/stat_bytes         - saturating statistics
//                                                (only with L1_MERGE_STATS_EN)
//  Config      : `define L1_MERGE_STATS_EN to add the statistics ports.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l1_cache_merge_buffer
    import lc3b_types::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int WORDS  = WORDS_DEF,
    parameter int BE_W   = WORD_W / 8,
    parameter int OFF_W  = $clog2(WORDS),
    parameter int LINE_W = WORD_W * WORDS
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                st_valid,
    output logic                st_ready,
    input  logic [OFF_W-1:0]    st_offset,
    input  logic [WORD_W-1:0]   st_wdata,
    input  logic [BE_W-1:0]     st_wmask,
    input  logic                base_valid,
    input  logic [LINE_W-1:0]   base_line,
    input  logic                commit,
    input  logic                abort,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LINE_W-1:0]   out_line,
    output logic [LINE_W/8-1:0] out_dirty,
    output logic                dup_base
`ifdef L1_MERGE_STATS_EN
    ,
    output logic [15:0]         stat_lines,
    output logic [15:0]         stat_bytes
`endif
);

    localparam int NBYTES = LINE_W / 8;

    merge_state_t state_q;
    logic         have_base_q;
    logic         out_valid_q;
    logic         st_ready_q;
    logic         dup_base_q;

    logic w_live;
    logic w_abort;
    logic w_st_accept;
    logic w_base_take;
    logic w_dup;
    logic w_out_hs;
    logic w_clr;
    logic w_commit;

    // Inputs are only acted on outside DRAIN; abort suppresses any same-cycle
    // store, base capture or commit.
    assign w_live      = (state_q != DRAIN);
    assign w_abort     = abort && w_live;
    assign w_st_accept = st_valid && st_ready_q && w_live && !abort;
    assign w_base_take = base_valid && w_live && !have_base_q && !abort;
    assign w_dup       = base_valid && have_base_q && (state_q == ACCUM);
    assign w_out_hs    = out_valid_q && out_ready;
    assign w_clr       = w_abort || w_out_hs;
    // A base arriving in the commit cycle is enough to close the line.
    assign w_commit    = (state_q == ACCUM) && commit && !abort &&
                         (have_base_q || base_valid);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            have_base_q <= 1'b0;
            out_valid_q <= 1'b0;
            st_ready_q  <= 1'b1;
            dup_base_q  <= 1'b0;
        end else begin
            dup_base_q <= w_dup;
            if (w_clr) begin
                state_q     <= IDLE;
                have_base_q <= 1'b0;
                out_valid_q <= 1'b0;
                st_ready_q  <= 1'b1;
            end else begin
                if (w_base_take) begin
                    have_base_q <= 1'b1;
                end
                case (state_q)
                    IDLE: begin
                        if (st_valid || base_valid) begin
                            state_q <= ACCUM;
                        end
                    end
                    ACCUM: begin
                        if (w_commit) begin
                            state_q     <= DRAIN;
                            out_valid_q <= 1'b1;
                            st_ready_q  <= 1'b0;
                        end
                    end
                    DRAIN: begin
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign st_ready  = st_ready_q;
    assign out_valid = out_valid_q;
    assign dup_base  = dup_base_q;

    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_lane
            logic w_st_we;
            assign w_st_we = w_st_accept &&
                             (st_offset == OFF_W'(gi / BE_W)) &&
                             st_wmask[gi % BE_W];

            l1_merge_byte_lane u_lane (
                .clk         (clk),
                .reset_n     (reset_n),
                .clr_i       (w_clr),
                .st_we_i     (w_st_we),
                .st_byte_i   (st_wdata[8*(gi % BE_W) +: 8]),
                .base_we_i   (w_base_take),
                .base_byte_i (base_line[8*gi +: 8]),
                .byte_o      (out_line[8*gi +: 8]),
                .dirty_o     (out_dirty[gi])
            );
        end
    endgenerate

`ifdef L1_MERGE_STATS_EN
    logic [15:0] stat_lines_q;
    logic [15:0] stat_bytes_q;
    logic [15:0] w_nbytes;
    logic [16:0] w_bytes_sum;

    assign w_nbytes    = w_st_accept ? 16'($countones(st_wmask)) : 16'd0;
    assign w_bytes_sum = {1'b0, stat_bytes_q} + {1'b0, w_nbytes};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_lines_q <= 16'd0;
            stat_bytes_q <= 16'd0;
        end else begin
            if (w_out_hs && (stat_lines_q != 16'hFFFF)) begin
                stat_lines_q <= stat_lines_q + 16'd1;
            end
            stat_bytes_q <= w_bytes_sum[16] ? 16'hFFFF : w_bytes_sum[15:0];
        end
    end

    assign stat_lines = stat_lines_q;
    assign stat_bytes = stat_bytes_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_l1_cache_merge_buffer.sv
// ============================================================================
//  Module      : tb_l1_cache_merge_buffer
//  Description : Directed self-checking bench for l1_cache_merge_buffer
//                (WORD_W=16, WORDS=16, LINE_W=256, 32 dirty bits).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l1_cache_merge_buffer;

    logic         clk;
    logic         reset_n;
    logic         st_valid;
    logic         st_ready;
    logic [3:0]   st_offset;
    logic [15:0]  st_wdata;
    logic [1:0]   st_wmask;
    logic         base_valid;
    logic [255:0] base_line;
    logic         commit;
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_line;
    logic [31:0]  out_dirty;
    logic         dup_base;
`ifdef L1_MERGE_STATS_EN
    logic [15:0]  stat_lines;
    logic [15:0]  stat_bytes;
`endif

    int checks   = 0;
    int failures = 0;

    l1_cache_merge_buffer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .st_offset  (st_offset),
        .st_wdata   (st_wdata),
        .st_wmask   (st_wmask),
        .base_valid (base_valid),
        .base_line  (base_line),
        .commit     (commit),
        .abort      (abort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_line   (out_line),
        .out_dirty  (out_dirty),
        .dup_base   (dup_base)
`ifdef L1_MERGE_STATS_EN
        ,
        .stat_lines (stat_lines),
        .stat_bytes (stat_bytes)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] fill(input logic [15:0] w);
        return {16{w}};
    endfunction

    task automatic store(input logic [3:0] off, input logic [15:0] d, input logic [1:0] m);
        st_valid  = 1'b1;
        st_offset = off;
        st_wdata  = d;
        st_wmask  = m;
    endtask

    logic [255:0] exp_line;

    initial begin
        reset_n    = 1'b0;
        st_valid   = 1'b0;
        st_offset  = 4'd0;
        st_wdata   = 16'h0;
        st_wmask   = 2'b00;
        base_valid = 1'b0;
        base_line  = '0;
        commit     = 1'b0;
        abort      = 1'b0;
        out_ready  = 1'b0;
        repeat (3) tick();
        chk("rst_st_ready",  256'(st_ready), 256'(1));
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_dup_base",  256'(dup_base), 256'(0));
        chk("rst_out_line",  out_line, 256'(0));
        chk("rst_out_dirty", 256'(out_dirty), 256'(0));
        reset_n = 1'b1;
        tick();

        // 1: base first, then one store, then commit
        base_valid = 1'b1; base_line = fill(16'h1111);
        tick();
        base_valid = 1'b0;
        store(4'd3, 16'hABCD, 2'b11);
        tick();
        st_valid = 1'b0; commit = 1'b1;
        tick();
        commit = 1'b0;
        exp_line = fill(16'h1111); exp_line[3*16 +: 16] = 16'hABCD;
        chk("t1_out_valid", 256'(out_valid), 256'(1));
        chk("t1_st_ready",  256'(st_ready), 256'(0));
        chk("t1_line",      out_line, exp_line);
        chk("t1_dirty",     256'(out_dirty), 256'(32'h0000_00C0));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t1_hs_valid",  256'(out_valid), 256'(0));
        chk("t1_hs_dirty",  256'(out_dirty), 256'(0));

        // 2: store before the L2 fill
        store(4'd0, 16'h00EE, 2'b01);
        tick();
        st_valid = 1'b0; base_valid = 1'b1; base_line = fill(16'h2222);
        tick();
        base_valid = 1'b0; commit = 1'b1;
        tick();
        commit = 1'b0;
        exp_line = fill(16'h2222); exp_line[15:0] = 16'h22EE;
        chk("t2_line",  out_line, exp_line);
        chk("t2_dirty", 256'(out_dirty), 256'(32'h0000_0001));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // 3: commit waits for the base
        store(4'd1, 16'h5555, 2'b11);
        tick();
        st_valid = 1'b0; commit = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("t3_wait_%0d", i), 256'(out_valid), 256'(0));
        end
        base_valid = 1'b1; base_line = fill(16'h3333);
        tick();
        base_valid = 1'b0; commit = 1'b0;
        exp_line = fill(16'h3333); exp_line[1*16 +: 16] = 16'h5555;
        chk("t3_out_valid", 256'(out_valid), 256'(1));
        chk("t3_line",      out_line, exp_line);
        chk("t3_dirty",     256'(out_dirty), 256'(32'h0000_000C));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // 4: overwrite, base after stores, store in the commit cycle
        store(4'd2, 16'h1234, 2'b11);
        tick();
        store(4'd2, 16'h5678, 2'b11);
        tick();
        st_valid = 1'b0; base_valid = 1'b1; base_line = fill(16'h4444);
        tick();
        base_valid = 1'b0;
        store(4'd5, 16'h9A9A, 2'b10); commit = 1'b1;
        tick();
        st_valid = 1'b0; commit = 1'b0;
        exp_line = fill(16'h4444);
        exp_line[2*16 +: 16] = 16'h5678;
        exp_line[5*16 +: 16] = 16'h9A44;
        chk("t4_out_valid", 256'(out_valid), 256'(1));
        chk("t4_line",      out_line, exp_line);
        chk("t4_dirty",     256'(out_dirty), 256'(32'h0000_0830));

        // 5: DRAIN stall with junk inputs, then a clean base-only line
        store(4'd2, 16'hFFFF, 2'b11); base_valid = 1'b1; base_line = fill(16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t5_st_ready_%0d", i), 256'(st_ready), 256'(0));
            chk($sformatf("t5_valid_%0d", i),    256'(out_valid), 256'(1));
            chk($sformatf("t5_line_%0d", i),     out_line, exp_line);
            chk($sformatf("t5_dirty_%0d", i),    256'(out_dirty), 256'(32'h0000_0830));
        end
        st_valid = 1'b0; base_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t5_idle_valid", 256'(out_valid), 256'(0));
        chk("t5_idle_ready", 256'(st_ready), 256'(1));
        chk("t5_idle_dirty", 256'(out_dirty), 256'(0));
        chk("t5_idle_line",  out_line, 256'(0));
        base_valid = 1'b1; base_line = fill(16'h6666);
        tick();
        base_valid = 1'b0; commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("t5_nostore_line",  out_line, fill(16'h6666));
        chk("t5_nostore_dirty", 256'(out_dirty), 256'(0));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // 6a: duplicate base is ignored and flagged
        base_valid = 1'b1; base_line = fill(16'h7777);
        tick();
        base_line = fill(16'h8888);
        tick();
        base_valid = 1'b0;
        chk("t6_dup_pulse", 256'(dup_base), 256'(1));
        tick();
        chk("t6_dup_clear", 256'(dup_base), 256'(0));
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("t6_dup_line", out_line, fill(16'h7777));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // 6b: abort beats commit
        store(4'd0, 16'hBEEF, 2'b11);
        tick();
        st_valid = 1'b0; base_valid = 1'b1; base_line = fill(16'h9999);
        commit = 1'b1; abort = 1'b1;
        tick();
        base_valid = 1'b0; commit = 1'b0; abort = 1'b0;
        chk("t6_abort_valid", 256'(out_valid), 256'(0));
        chk("t6_abort_dirty", 256'(out_dirty), 256'(0));
        chk("t6_abort_line",  out_line, 256'(0));
        tick();
        chk("t6_abort_valid2", 256'(out_valid), 256'(0));

        // 6c: asynchronous reset in DRAIN
        base_valid = 1'b1; base_line = fill(16'hAAAA);
        tick();
        base_valid = 1'b0; commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("t6_drain_valid", 256'(out_valid), 256'(1));
        #2 reset_n = 1'b0;
        #1;
        chk("t6_arst_valid", 256'(out_valid), 256'(0));
        chk("t6_arst_line",  out_line, 256'(0));
        chk("t6_arst_ready", 256'(st_ready), 256'(1));
        tick();
        reset_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
